// File: rtl/s2c_pattern_checker_pkg.sv
// Shared definitions for the S2C counter-pattern checker: register map,
// CTRL/STATUS bit positions, checker state encoding and statistics bundle.
package s2c_checker_pkg;

    localparam int PATTERN_W = 32;

    // Register word indices (byte offset >> 2); only addr[4:2] is decoded.
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_BEATS    = 3'd2;
    localparam logic [2:0] REG_PKTS     = 3'd3;
    localparam logic [2:0] REG_ERRORS   = 3'd4;
    localparam logic [2:0] REG_LAST_EXP = 3'd5;
    localparam logic [2:0] REG_LAST_GOT = 3'd6;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_CLEAR_BIT    = 1;
    localparam int STATUS_LOCKED_BIT = 0;
    localparam int STATUS_STICKY_BIT = 1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } chk_state_e;

    // Everything the register block needs to show the host.
    typedef struct packed {
        logic                 locked;
        logic                 sticky_err;
        logic [PATTERN_W-1:0] beats;
        logic [PATTERN_W-1:0] pkts;
        logic [PATTERN_W-1:0] errors;
        logic [PATTERN_W-1:0] last_exp;
        logic [PATTERN_W-1:0] last_got;
    } stat_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PATTERN_W-1:0] sat_inc(input logic [PATTERN_W-1:0] v);
        return (v == {PATTERN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/s2c_pattern_checker_if.sv
// Bus bundle for the checker: AXI-Lite register port plus the S2C AXI-Stream
// port. "master" is the host/DMA side, "slave" is the checker side.
interface s2c_pattern_checker_if #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TDATA_W = 256
);
    logic                 s_axi_lite_awvalid;
    logic                 s_axi_lite_awready;
    logic [ADDR_W-1:0]    s_axi_lite_awaddr;
    logic                 s_axi_lite_wvalid;
    logic                 s_axi_lite_wready;
    logic [DATA_W-1:0]    s_axi_lite_wdata;
    logic [DATA_W/8-1:0]  s_axi_lite_wstrb;
    logic                 s_axi_lite_bvalid;
    logic                 s_axi_lite_bready;
    logic [1:0]           s_axi_lite_bresp;
    logic                 s_axi_lite_arvalid;
    logic                 s_axi_lite_arready;
    logic [ADDR_W-1:0]    s_axi_lite_araddr;
    logic                 s_axi_lite_rvalid;
    logic                 s_axi_lite_rready;
    logic [DATA_W-1:0]    s_axi_lite_rdata;
    logic [1:0]           s_axi_lite_rresp;

    logic                 s2c_tvalid;
    logic                 s2c_tready;
    logic [TDATA_W-1:0]   s2c_tdata;
    logic [TDATA_W/8-1:0] s2c_tkeep;
    logic                 s2c_tlast;

    modport master (
        output s_axi_lite_awvalid, s_axi_lite_awaddr, s_axi_lite_wvalid,
               s_axi_lite_wdata, s_axi_lite_wstrb, s_axi_lite_bready,
               s_axi_lite_arvalid, s_axi_lite_araddr, s_axi_lite_rready,
               s2c_tvalid, s2c_tdata, s2c_tkeep, s2c_tlast,
        input  s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bvalid,
               s_axi_lite_bresp, s_axi_lite_arready, s_axi_lite_rvalid,
               s_axi_lite_rdata, s_axi_lite_rresp, s2c_tready
    );

    modport slave (
        input  s_axi_lite_awvalid, s_axi_lite_awaddr, s_axi_lite_wvalid,
               s_axi_lite_wdata, s_axi_lite_wstrb, s_axi_lite_bready,
               s_axi_lite_arvalid, s_axi_lite_araddr, s_axi_lite_rready,
               s2c_tvalid, s2c_tdata, s2c_tkeep, s2c_tlast,
        output s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bvalid,
               s_axi_lite_bresp, s_axi_lite_arready, s_axi_lite_rvalid,
               s_axi_lite_rdata, s_axi_lite_rresp, s2c_tready
    );

endinterface

// File: rtl/s2c_pattern_checker_regs.sv
// AXI-Lite slave and register file for the pattern checker. Holds CTRL,
// generates the one-cycle clear pulse and muxes the statistics for reads.
module s2c_checker_regs
    import s2c_checker_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [2:0]  i_awaddr,
    input  logic        i_wvalid,
    output logic        o_wready,
    input  logic [1:0]  i_wdata,
    input  logic        i_wstrb0,
    output logic        o_bvalid,
    input  logic        i_bready,
    output logic [1:0]  o_bresp,
    input  logic        i_arvalid,
    output logic        o_arready,
    input  logic [2:0]  i_araddr,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_ctrl_enable,
    output logic        o_clear_pulse,
    input  stat_t       i_stat
);

    logic        r_awready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_enable;
    logic        r_clear;
    logic [31:0] w_rd_mux;

    // Read data selection; clear is write-only and always reads back as 0.
    always_comb begin
        w_rd_mux = 32'h0;
        case (i_araddr)
            REG_CTRL: begin
                w_rd_mux[CTRL_ENABLE_BIT] = r_enable;
            end
            REG_STATUS: begin
                w_rd_mux[STATUS_LOCKED_BIT] = i_stat.locked;
                w_rd_mux[STATUS_STICKY_BIT] = i_stat.sticky_err;
            end
            REG_BEATS:    w_rd_mux = i_stat.beats;
            REG_PKTS:     w_rd_mux = i_stat.pkts;
            REG_ERRORS:   w_rd_mux = i_stat.errors;
            REG_LAST_EXP: w_rd_mux = i_stat.last_exp;
            REG_LAST_GOT: w_rd_mux = i_stat.last_got;
            default:      w_rd_mux = 32'h0;
        endcase
    end

    // Write channel: single-cycle aw/w ready, then hold bvalid until bready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_enable  <= 1'b1;
            r_clear   <= 1'b0;
        end else begin
            r_clear   <= 1'b0;
            r_awready <= i_awvalid & i_wvalid & ~r_bvalid & ~r_awready;
            if (r_awready) begin
                r_bvalid <= 1'b1;
                if (i_awaddr == REG_CTRL && i_wstrb0) begin
                    r_enable <= i_wdata[CTRL_ENABLE_BIT];
                    r_clear  <= i_wdata[CTRL_CLEAR_BIT];
                end
            end else if (r_bvalid && i_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: single-cycle arready, registered data held until rready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            r_arready <= i_arvalid & ~r_rvalid & ~r_arready;
            if (r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && i_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign o_awready     = r_awready;
    assign o_wready      = r_awready;
    assign o_bvalid      = r_bvalid;
    assign o_bresp       = 2'b00;
    assign o_arready     = r_arready;
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = r_rdata;
    assign o_rresp       = 2'b00;
    assign o_ctrl_enable = r_enable;
    assign o_clear_pulse = r_clear;

endmodule

// File: rtl/s2c_pattern_checker.sv
// S2C stream sink that checks every beat against an incrementing 32-bit
// counter (upper data bits zero, all bytes kept) and keeps statistics that
// the host reads through the AXI-Lite register block.
module s2c_pattern_checker
    import s2c_checker_pkg::*;
#(
    parameter int C_S_AXI_LITE_ADDR_WIDTH = 9,
    parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
    parameter int C_TDATA_WIDTH           = 256
) (
    input  logic                  m_axi_lite_aclk,
    input  logic                  m_axi_lite_aresetn,
    s2c_pattern_checker_if.slave  s_bus
);

    localparam int TKEEP_W = C_TDATA_WIDTH / 8;

    chk_state_e           r_state;
    logic [PATTERN_W-1:0] r_exp;
    logic [PATTERN_W-1:0] r_beats;
    logic [PATTERN_W-1:0] r_pkts;
    logic [PATTERN_W-1:0] r_errors;
    logic [PATTERN_W-1:0] r_last_exp;
    logic [PATTERN_W-1:0] r_last_got;
    logic                 r_sticky_err;

    logic                 w_enable;
    logic                 w_clear;
    logic                 w_beat;
    logic [PATTERN_W-1:0] w_data;
    logic                 w_err;
    stat_t                w_stat;

    // Pure sink: never backpressure the DMA engine.
    assign s_bus.s2c_tready = 1'b1;
    assign w_beat = s_bus.s2c_tvalid;
    assign w_data = s_bus.s2c_tdata[PATTERN_W-1:0];
    assign w_err  = (w_data != r_exp)
                  | (|s_bus.s2c_tdata[C_TDATA_WIDTH-1:PATTERN_W])
                  | (s_bus.s2c_tkeep != {TKEEP_W{1'b1}});

    // Checker FSM and statistics; clear has priority over a same-cycle beat.
    always_ff @(posedge m_axi_lite_aclk or negedge m_axi_lite_aresetn) begin
        if (!m_axi_lite_aresetn) begin
            r_state      <= ST_UNLOCKED;
            r_exp        <= '0;
            r_beats      <= '0;
            r_pkts       <= '0;
            r_errors     <= '0;
            r_last_exp   <= '0;
            r_last_got   <= '0;
            r_sticky_err <= 1'b0;
        end else if (w_clear) begin
            r_state      <= ST_UNLOCKED;
            r_beats      <= '0;
            r_pkts       <= '0;
            r_errors     <= '0;
            r_last_exp   <= '0;
            r_last_got   <= '0;
            r_sticky_err <= 1'b0;
        end else if (!w_enable) begin
            r_state <= ST_UNLOCKED;
        end else if (w_beat) begin
            r_beats <= r_beats + 1'b1;
            if (s_bus.s2c_tlast) begin
                r_pkts <= r_pkts + 1'b1;
            end
            // Always resync to what arrived so one bad beat costs one error.
            r_exp <= w_data + 1'b1;
            case (r_state)
                ST_UNLOCKED: r_state <= ST_LOCKED;
                ST_LOCKED: begin
                    if (w_err) begin
                        r_errors     <= sat_inc(r_errors);
                        r_last_exp   <= r_exp;
                        r_last_got   <= w_data;
                        r_sticky_err <= 1'b1;
                    end
                end
                default: r_state <= ST_UNLOCKED;
            endcase
        end
    end

    assign w_stat.locked     = (r_state == ST_LOCKED);
    assign w_stat.sticky_err = r_sticky_err;
    assign w_stat.beats      = r_beats;
    assign w_stat.pkts       = r_pkts;
    assign w_stat.errors     = r_errors;
    assign w_stat.last_exp   = r_last_exp;
    assign w_stat.last_got   = r_last_got;

    s2c_checker_regs u_regs (
        .i_clk         (m_axi_lite_aclk),
        .i_rst_n       (m_axi_lite_aresetn),
        .i_awvalid     (s_bus.s_axi_lite_awvalid),
        .o_awready     (s_bus.s_axi_lite_awready),
        .i_awaddr      (s_bus.s_axi_lite_awaddr[4:2]),
        .i_wvalid      (s_bus.s_axi_lite_wvalid),
        .o_wready      (s_bus.s_axi_lite_wready),
        .i_wdata       (s_bus.s_axi_lite_wdata[1:0]),
        .i_wstrb0      (s_bus.s_axi_lite_wstrb[0]),
        .o_bvalid      (s_bus.s_axi_lite_bvalid),
        .i_bready      (s_bus.s_axi_lite_bready),
        .o_bresp       (s_bus.s_axi_lite_bresp),
        .i_arvalid     (s_bus.s_axi_lite_arvalid),
        .o_arready     (s_bus.s_axi_lite_arready),
        .i_araddr      (s_bus.s_axi_lite_araddr[4:2]),
        .o_rvalid      (s_bus.s_axi_lite_rvalid),
        .i_rready      (s_bus.s_axi_lite_rready),
        .o_rdata       (s_bus.s_axi_lite_rdata),
        .o_rresp       (s_bus.s_axi_lite_rresp),
        .o_ctrl_enable (w_enable),
        .o_clear_pulse (w_clear),
        .i_stat        (w_stat)
    );

endmodule

// File: tb/tb_s2c_pattern_checker.sv
// Directed bench for s2c_pattern_checker: a table of beats with expected
// counters, plus hand-written sequences for clear, disable and reset.
module tb_s2c_pattern_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    s2c_pattern_checker_if bus ();

    s2c_pattern_checker dut (
        .m_axi_lite_aclk    (clk),
        .m_axi_lite_aresetn (rst_n),
        .s_bus              (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] keep;
        logic        hi;
        logic        last;
        logic        clr;
        logic [31:0] e_beats;
        logic [31:0] e_pkts;
        logic [31:0] e_errs;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [31:0] d, input logic [31:0] keep,
                                input logic hi, input logic last, input logic clr,
                                input logic [31:0] eb, input logic [31:0] ep,
                                input logic [31:0] ee);
        vec_t v;
        v.data = d; v.keep = keep; v.hi = hi; v.last = last; v.clr = clr;
        v.e_beats = eb; v.e_pkts = ep; v.e_errs = ee;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [31:0] keep,
                              input logic hi, input logic last);
        bus.s2c_tdata       = '0;
        bus.s2c_tdata[31:0] = d;
        bus.s2c_tdata[40]   = hi;
        bus.s2c_tkeep       = keep;
        bus.s2c_tlast       = last;
        bus.s2c_tvalid      = 1'b1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [31:0] keep,
                             input logic hi, input logic last);
        drive_beat(d, keep, hi, last);
        check("tready", {31'b0, bus.s2c_tready}, 32'h1);
        $display("BEAT data=0x%08h keep=0x%08h hi=%0d last=%0d", d, keep, hi, last);
        tick();
        bus.s2c_tvalid = 1'b0;
        bus.s2c_tlast  = 1'b0;
    endtask

    // AXI-Lite write; optionally present a stream beat in the cycle right
    // after the write handshake (the cycle in which CTRL takes effect).
    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic with_beat,
                             input logic [31:0] beat_d);
        bit ok;
        bus.s_axi_lite_awaddr  = addr;
        bus.s_axi_lite_wdata   = data;
        bus.s_axi_lite_wstrb   = strb;
        bus.s_axi_lite_awvalid = 1'b1;
        bus.s_axi_lite_wvalid  = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (bus.s_axi_lite_awready && bus.s_axi_lite_wready) ok = 1;
        end
        if (!ok) timeout("awready");
        tick();
        bus.s_axi_lite_awvalid = 1'b0;
        bus.s_axi_lite_wvalid  = 1'b0;
        if (with_beat) drive_beat(beat_d, 32'hFFFFFFFF, 1'b0, 1'b0);
        ok = bus.s_axi_lite_bvalid;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (bus.s_axi_lite_bvalid) ok = 1;
        end
        if (!ok) timeout("bvalid");
        check("bresp", {30'b0, bus.s_axi_lite_bresp}, 32'h0);
        bus.s_axi_lite_bready = 1'b1;
        tick();
        bus.s_axi_lite_bready = 1'b0;
        bus.s2c_tvalid = 1'b0;
        $display("WR addr=0x%03h data=0x%08h strb=0x%h", addr, data, strb);
    endtask

    task automatic axi_read(input logic [8:0] addr, output logic [31:0] data);
        bit ok;
        data = 32'hX;
        bus.s_axi_lite_araddr  = addr;
        bus.s_axi_lite_arvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (bus.s_axi_lite_arready) ok = 1;
        end
        if (!ok) timeout("arready");
        tick();
        bus.s_axi_lite_arvalid = 1'b0;
        ok = bus.s_axi_lite_rvalid;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (bus.s_axi_lite_rvalid) ok = 1;
        end
        if (!ok) timeout("rvalid");
        data = bus.s_axi_lite_rdata;
        bus.s_axi_lite_rready = 1'b1;
        tick();
        bus.s_axi_lite_rready = 1'b0;
        $display("RD addr=0x%03h data=0x%08h", addr, data);
    endtask

    task automatic rd_chk(input string name, input logic [8:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(name, d, exp);
    endtask

    initial begin
        bus.s_axi_lite_awvalid = 0; bus.s_axi_lite_awaddr = '0;
        bus.s_axi_lite_wvalid  = 0; bus.s_axi_lite_wdata  = '0;
        bus.s_axi_lite_wstrb   = '0; bus.s_axi_lite_bready = 0;
        bus.s_axi_lite_arvalid = 0; bus.s_axi_lite_araddr = '0;
        bus.s_axi_lite_rready  = 0;
        bus.s2c_tvalid = 0; bus.s2c_tdata = '0; bus.s2c_tkeep = '0; bus.s2c_tlast = 0;

        // Beats between clears with cumulative expected BEATS/PKTS/ERRORS.
        for (int i = 0; i < 8; i++)
            add(32'h10 + i, 32'hFFFFFFFF, 0, (i == 7), (i == 0), i + 1, (i == 7) ? 1 : 0, 0);
        add(32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0);
        add(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 2, 0, 0);
        add(32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 3, 0, 0);
        add(32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 4, 0, 0);
        add(32'h100, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0);
        add(32'h101, 32'hFFFFFFFF, 1, 0, 0, 2, 0, 1);
        add(32'h102, 32'h0000FFFF, 0, 0, 0, 3, 0, 2);
        add(32'h103, 32'hFFFFFFFF, 0, 0, 0, 4, 0, 2);
        add(32'd5,  32'hFFFFFFFF, 0, 0, 1, 1, 0, 0);
        add(32'd6,  32'hFFFFFFFF, 0, 0, 0, 2, 0, 0);
        add(32'd9,  32'hFFFFFFFF, 0, 0, 0, 3, 0, 1);
        add(32'd10, 32'hFFFFFFFF, 0, 0, 0, 4, 0, 1);
        add(32'd11, 32'hFFFFFFFF, 0, 1, 0, 5, 1, 1);

        repeat (3) tick();
        check("rst_tready",  {31'b0, bus.s2c_tready}, 32'h1);
        check("rst_awready", {31'b0, bus.s_axi_lite_awready}, 32'h0);
        check("rst_bvalid",  {31'b0, bus.s_axi_lite_bvalid}, 32'h0);
        check("rst_rvalid",  {31'b0, bus.s_axi_lite_rvalid}, 32'h0);
        check("rst_rdata",   bus.s_axi_lite_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        rd_chk("rst_ctrl",     9'h00, 32'h1);
        rd_chk("rst_status",   9'h04, 32'h0);
        rd_chk("rst_beats",    9'h08, 32'h0);
        rd_chk("rst_pkts",     9'h0C, 32'h0);
        rd_chk("rst_errors",   9'h10, 32'h0);
        rd_chk("rst_last_exp", 9'h14, 32'h0);
        rd_chk("rst_last_got", 9'h18, 32'h0);
        rd_chk("unmapped",     9'h1C, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            if (v.clr) axi_write(9'h00, 32'h3, 4'hF, 1'b0, 32'h0);
            send_beat(v.data, v.keep, v.hi, v.last);
            rd_chk($sformatf("v%0d_beats", i), 9'h08, v.e_beats);
            rd_chk($sformatf("v%0d_pkts", i), 9'h0C, v.e_pkts);
            rd_chk($sformatf("v%0d_errors", i), 9'h10, v.e_errs);
        end

        // Error capture from the 5,6,9,10,11 run.
        rd_chk("last_exp", 9'h14, 32'd7);
        rd_chk("last_got", 9'h18, 32'd9);
        rd_chk("status_err", 9'h04, 32'h3);

        // Writes to read-only registers are ignored.
        axi_write(9'h08, 32'hDEAD, 4'hF, 1'b0, 32'h0);
        rd_chk("ro_beats", 9'h08, 32'd5);

        // Clear in the same cycle as a beat: clear wins, then relock cleanly.
        send_beat(32'h20, 32'hFFFFFFFF, 0, 0);
        rd_chk("pre_clr_errors", 9'h10, 32'd2);
        axi_write(9'h00, 32'h3, 4'hF, 1'b1, 32'h50);
        rd_chk("clr_beats",    9'h08, 32'h0);
        rd_chk("clr_pkts",     9'h0C, 32'h0);
        rd_chk("clr_errors",   9'h10, 32'h0);
        rd_chk("clr_last_exp", 9'h14, 32'h0);
        rd_chk("clr_last_got", 9'h18, 32'h0);
        rd_chk("clr_status",   9'h04, 32'h0);
        rd_chk("clr_ctrl",     9'h00, 32'h1);
        send_beat(32'h99, 32'hFFFFFFFF, 0, 0);
        rd_chk("relock_status", 9'h04, 32'h1);
        rd_chk("relock_errors", 9'h10, 32'h0);
        send_beat(32'h9A, 32'hFFFFFFFF, 0, 0);
        rd_chk("relock_beats",  9'h08, 32'd2);
        rd_chk("relock_errors2", 9'h10, 32'h0);

        // wstrb[0]=0 leaves CTRL untouched.
        axi_write(9'h00, 32'h0, 4'hE, 1'b0, 32'h0);
        rd_chk("strb_ctrl", 9'h00, 32'h1);

        // Disabled: beats accepted but not counted; checker unlocks.
        axi_write(9'h00, 32'h0, 4'hF, 1'b0, 32'h0);
        rd_chk("dis_ctrl", 9'h00, 32'h0);
        for (int i = 0; i < 4; i++) send_beat(32'h500 + i * 7, 32'hFFFFFFFF, 0, 1);
        rd_chk("dis_beats",  9'h08, 32'd2);
        rd_chk("dis_pkts",   9'h0C, 32'd0);
        rd_chk("dis_status", 9'h04, 32'h0);

        // Reset in the middle of a stream.
        axi_write(9'h00, 32'h1, 4'hF, 1'b0, 32'h0);
        send_beat(32'h40, 32'hFFFFFFFF, 0, 0);
        send_beat(32'h41, 32'hFFFFFFFF, 0, 0);
        drive_beat(32'h42, 32'hFFFFFFFF, 0, 0);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        bus.s2c_tvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        rd_chk("mid_rst_beats",  9'h08, 32'h0);
        rd_chk("mid_rst_errors", 9'h10, 32'h0);
        rd_chk("mid_rst_status", 9'h04, 32'h0);
        rd_chk("mid_rst_ctrl",   9'h00, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
